alu_seq: RTL and testbench

Handshake-driven ALU sequencer: the next generation of the 2-bit confirm/execute ALU FSM. It captures operands on a request, waits for an operation confirm with a timeout, and executes one operation. It then holds a registered result and flags until the consumer acknowledges. It sits between the switch/button front-end (debounced handshaking/confirm_op) and the display/result logic.

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/alu_core.sv | 59 +++++
 rtl/alu_seq.sv | 137 +++++++++++++
 tb/tb_alu_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: opcodes, FSM states, flag indices.
// Imported by alu_core and alu_seq.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_SLT = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus {n,z,c,v} flags for one opcode.
// SUB reports borrow in c; shifts use the low log2(WIDTH) bits of b.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0]  sum;
    logic [WIDTH:0]  dif;
    logic [SW-1:0]   sh;
    logic            c;
    logic            v;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        dif = {1'b0, a} - {1'b0, b};
        sh  = b[SW-1:0];
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (op)
            OP_ADD: begin
                y = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) &&
                    (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // dif[WIDTH] is set exactly when a < b unsigned
                y = dif[WIDTH-1:0];
                c = dif[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) &&
                    (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SLL: y = a << sh;
            OP_SRL: y = a >> sh;
            OP_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
        flags        = '0;
        flags[FLG_N] = y[WIDTH-1];
        flags[FLG_Z] = (y == '0);
        flags[FLG_C] = c;
        flags[FLG_V] = v;
    end

endmodule

// File: rtl/alu_seq.sv
// Request/confirm ALU sequencer: capture operands, await opcode with
// timeout, execute once, hold result until acknowledged.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             handshaking,
    input  logic             confirm_op,
    input  logic [2:0]       switch_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             result_ack,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       flags,
    output logic             result_valid,
    output logic             busy,
    output logic             timeout
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    op_e              op_q;
    logic [TW-1:0]    timer_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flg_q;
    logic             to_q;

    logic             ld_ops;
    logic             ld_op;
    logic             ld_res;
    logic             to_fire;
    logic             tmr_inc;

    logic [WIDTH-1:0] core_y;
    logic [3:0]       core_f;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .y     (core_y),
        .flags (core_f)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ld_ops  = 1'b0;
        ld_op   = 1'b0;
        ld_res  = 1'b0;
        to_fire = 1'b0;
        tmr_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (handshaking) begin
                    ld_ops  = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // confirm takes priority over an expiring timer
                if (confirm_op) begin
                    ld_op   = 1'b1;
                    state_d = EXEC;
                end else if (TIMEOUT != 0 && timer_q == T_LAST) begin
                    to_fire = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            EXEC: begin
                ld_res  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (result_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            timer_q <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            to_q <= to_fire;
            if (ld_ops) begin
                a_q     <= operand_a;
                b_q     <= operand_b;
                timer_q <= '0;
            end else if (tmr_inc && timer_q != '1) begin
                timer_q <= timer_q + 1'b1;
            end
            if (ld_op) begin
                op_q <= op_e'(switch_op);
            end
            if (ld_res) begin
                res_q <= core_y;
                flg_q <= core_f;
            end
        end
    end

    assign alu_result   = res_q;
    assign flags        = flg_q;
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign timeout      = to_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8, TIMEOUT=4).
// Expected results and flags are hand-computed constants.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       handshaking;
    logic       confirm_op;
    logic [2:0] switch_op;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       result_ack;
    logic [7:0] alu_result;
    logic [3:0] flags;
    logic       result_valid;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    alu_seq #(
        .WIDTH   (8),
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .handshaking  (handshaking),
        .confirm_op   (confirm_op),
        .switch_op    (switch_op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .result_ack   (result_ack),
        .alu_result   (alu_result),
        .flags        (flags),
        .result_valid (result_valid),
        .busy         (busy),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction; operands/opcode are corrupted after capture
    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] op,
                          input logic [7:0] ey, input logic [3:0] ef);
        handshaking = 1'b1;
        operand_a   = a;
        operand_b   = b;
        step();
        chk({tag, "_armed"}, 32'(busy), 32'd1);
        handshaking = 1'b0;
        operand_a   = ~a;
        operand_b   = ~b;
        confirm_op  = 1'b1;
        switch_op   = op;
        step();
        confirm_op  = 1'b0;
        switch_op   = ~op;
        chk({tag, "_exec_nv"}, 32'(result_valid), 32'd0);
        step();
        chk({tag, "_y"}, 32'(alu_result), 32'(ey));
        chk({tag, "_f"}, 32'(flags), 32'(ef));
        chk({tag, "_v"}, 32'(result_valid), 32'd1);
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk({tag, "_ack_v"}, 32'(result_valid), 32'd0);
        chk({tag, "_ack_y"}, 32'(alu_result), 32'(ey));
    endtask

    initial begin
        reset       = 1'b1;
        handshaking = 1'b0;
        confirm_op  = 1'b0;
        switch_op   = 3'd0;
        operand_a   = 8'd0;
        operand_b   = 8'd0;
        result_ack  = 1'b0;
        #2;
        chk("rst_y", 32'(alu_result), 32'd0);
        chk("rst_f", 32'(flags), 32'd0);
        chk("rst_v", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // ADD 200+100 with DONE hold and ignored handshake
        handshaking = 1'b1;
        operand_a   = 8'd200;
        operand_b   = 8'd100;
        step();
        handshaking = 1'b0;
        confirm_op  = 1'b1;
        switch_op   = 3'd0;
        operand_a   = 8'd1;
        step();
        confirm_op  = 1'b0;
        step();
        chk("add_y", 32'(alu_result), 32'd44);
        chk("add_f", 32'(flags), 32'b0010);
        for (int i = 0; i < 3; i++) begin
            handshaking = ~handshaking;
            operand_a   = 8'(i * 37);
            operand_b   = 8'(i * 91);
            step();
            chk("hold_v", 32'(result_valid), 32'd1);
            chk("hold_y", 32'(alu_result), 32'd44);
        end
        handshaking = 1'b0;
        result_ack  = 1'b1;
        step();
        result_ack = 1'b0;
        chk("add_ack_busy", 32'(busy), 32'd0);
        chk("add_ack_y", 32'(alu_result), 32'd44);

        run_op("sub",  8'h05, 8'h07, 3'd1, 8'hFE, 4'b1010);
        run_op("ovf",  8'h7F, 8'h01, 3'd0, 8'h80, 4'b1001);
        run_op("addz", 8'hFF, 8'h01, 3'd0, 8'h00, 4'b0110);
        run_op("sll",  8'h81, 8'h09, 3'd5, 8'h02, 4'b0000);
        run_op("srl",  8'h81, 8'h09, 3'd6, 8'h40, 4'b0000);
        run_op("slt",  8'h80, 8'h01, 3'd7, 8'h01, 4'b0000);
        run_op("and",  8'h00, 8'h00, 3'd2, 8'h00, 4'b0100);
        run_op("xor",  8'hAA, 8'hAA, 3'd4, 8'h00, 4'b0100);
        run_op("or",   8'hF0, 8'h0F, 3'd3, 8'hFF, 4'b1000);

        // Timeout after 4 ARMED cycles without confirm
        handshaking = 1'b1;
        operand_a   = 8'h01;
        operand_b   = 8'h02;
        step();
        handshaking = 1'b0;
        step();
        step();
        step();
        chk("to_pre", 32'(timeout), 32'd0);
        chk("to_pre_busy", 32'(busy), 32'd1);
        step();
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_y", 32'(alu_result), 32'hFF);
        step();
        chk("to_end", 32'(timeout), 32'd0);

        // Confirm on the last ARMED cycle wins over timeout
        handshaking = 1'b1;
        operand_a   = 8'd10;
        operand_b   = 8'd3;
        step();
        handshaking = 1'b0;
        step();
        step();
        step();
        confirm_op = 1'b1;
        switch_op  = 3'd1;
        step();
        confirm_op = 1'b0;
        chk("cw_to", 32'(timeout), 32'd0);
        chk("cw_busy", 32'(busy), 32'd1);
        step();
        chk("cw_y", 32'(alu_result), 32'd7);
        chk("cw_f", 32'(flags), 32'b0000);
        chk("cw_v", 32'(result_valid), 32'd1);
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;

        // Async reset while in DONE
        handshaking = 1'b1;
        operand_a   = 8'h40;
        operand_b   = 8'h40;
        step();
        handshaking = 1'b0;
        confirm_op  = 1'b1;
        switch_op   = 3'd0;
        step();
        confirm_op = 1'b0;
        step();
        chk("rd_pre_y", 32'(alu_result), 32'h80);
        #2 reset = 1'b1;
        #1;
        chk("rd_y", 32'(alu_result), 32'd0);
        chk("rd_f", 32'(flags), 32'd0);
        chk("rd_v", 32'(result_valid), 32'd0);
        chk("rd_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Async reset while in EXEC
        handshaking = 1'b1;
        operand_a   = 8'h33;
        operand_b   = 8'h11;
        step();
        handshaking = 1'b0;
        confirm_op  = 1'b1;
        step();
        confirm_op = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("re_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("re_post_v", 32'(result_valid), 32'd0);
        chk("re_post_y", 32'(alu_result), 32'd0);

        run_op("post", 8'h10, 8'h20, 3'd0, 8'h30, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
